mips_cache_controller: RTL
==========================

MIPS_CACHE_CONTROLLER -- requirements
Module: mips_cache_controller

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the hit and miss statistics counters.
REQ-002 SHALL have ports clk (in, 1, clock) and rst (in, 1, reset); one clock, rst synchronous active-high.
REQ-003 SHALL have CPU-side inputs read_en (1), write_en (1), writedata (32) and byte_en (4).
REQ-004 SHALL have CPU-side output cpu_stall (1), the combined stall to the CPU.
REQ-005 SHALL have cache-side inputs cache_stall (1, cache miss) and data_addr (32, miss address from the cache).
REQ-006 SHALL have cache-side outputs data_in (32, fill word) and data_valid (1, one-cycle fill strobe).
REQ-007 SHALL have Avalon-MM memory outputs mem_address (32), mem_read (1), mem_write (1), mem_writedata (32) and mem_byteenable (4).
REQ-008 SHALL have Avalon-MM memory inputs mem_waitrequest (1) and mem_readdata (32).
REQ-009 SHALL have status outputs hit_count (CNT_W) and miss_count (CNT_W).

Function
REQ-010 SHALL implement FSM states IDLE, RD_WAIT, FILL, WR_WAIT and WR_DONE.
REQ-011 IDLE, read_en & cache_stall: latch data_addr, go to RD_WAIT, increment miss_count.
REQ-012 IDLE, read_en & !cache_stall: stay in IDLE, increment hit_count, cpu_stall = 0.
REQ-013 IDLE, write_en & cache_stall & byte_en != 4'b1111: write-allocate; latch address, writedata and byte_en; go to RD_WAIT; increment miss_count.
REQ-014 IDLE, write_en otherwise: latch address, writedata and byte_en; go to WR_WAIT; increment hit_count if !cache_stall, else miss_count.
REQ-015 read_en & write_en both high SHALL be treated as a read.
REQ-016 RD_WAIT: mem_read = 1, mem_byteenable = 4'b1111, mem_address = latched address; on !mem_waitrequest, register mem_readdata into data_in and go to FILL.
REQ-017 FILL: data_valid = 1 for exactly one cycle; next state WR_WAIT if the op is a write, else IDLE.
REQ-018 FILL: if data_addr != latched address, data_valid SHALL stay 0 (stale fill dropped) and the FSM SHALL return to IDLE.
REQ-019 WR_WAIT: mem_write = 1 with latched address, data and byte_en held stable; on !mem_waitrequest go to WR_DONE (write-through).
REQ-020 WR_DONE: cpu_stall = 0 for one cycle so the CPU retires the write; next state is IDLE.
REQ-021 cpu_stall SHALL be 1 in RD_WAIT, FILL and WR_WAIT.
REQ-022 In IDLE, cpu_stall = cache_stall when read_en is high, 1 when write_en is high, and 0 otherwise.
REQ-023 mem_read and mem_write SHALL never both be 1, and each SHALL stay asserted until accepted.
REQ-024 Counters SHALL saturate at all-ones and never wrap.
REQ-025 Read latency: a miss with zero-wait memory SHALL show data_valid 2 cycles after the request cycle, and cpu_stall SHALL fall the cycle after that.

Reset
REQ-026 On rst, the FSM SHALL go to IDLE on the next edge, even mid-transaction.
REQ-027 On rst, mem_read, mem_write, data_valid and both counters SHALL reset to 0.
REQ-028 On rst, data_in, mem_address, mem_writedata and mem_byteenable SHALL reset to 0.
REQ-029 A transaction aborted by reset SHALL NOT be resumed.

Structure
REQ-030 FSM state enum and Avalon constants (BE_WORD = 4'b1111) SHALL live in package mips_cache_pkg, shared with mips_cache_data.
REQ-031 The saturating counter SHALL be sub-module mips_sat_counter, instantiated twice.
REQ-032 The FSM, latches and Avalon drive SHALL be in the top module.

Verification
REQ-033 Read hit: read_en = 1, cache_stall = 0 -> cpu_stall = 0, no mem_read, hit_count 0 -> 1.
REQ-034 Read miss at 0x0000_0010, waitrequest high 3 cycles, readdata 0xDEADBEEF -> mem_read held 4 cycles, then data_valid pulses once with data_in = 0xDEADBEEF, miss_count = 1.
REQ-035 Partial write miss, byte_en 4'b0011, writedata 0x1234_5678 -> RD_WAIT, FILL, then WR_WAIT with mem_byteenable 4'b0011, mem_writedata 0x1234_5678, then one WR_DONE cycle.
REQ-036 Full write hit, byte_en 4'b1111 -> no mem_read; mem_write until accepted; cpu_stall low only in WR_DONE.
REQ-037 rst asserted in RD_WAIT while waitrequest = 1 -> next cycle mem_read = 0, IDLE, counters 0, no data_valid.
REQ-038 CNT_W = 4, 20 read hits -> hit_count stops at 4'hF.

Source files
------------

// File: rtl/mips_cache_pkg.sv
// mips_cache_pkg: shared FSM state encoding and Avalon-MM constants for the cache controller
package mips_cache_pkg;
    typedef enum logic [2:0] {IDLE, RD_WAIT, FILL, WR_WAIT, WR_DONE} state_e;
    localparam logic [3:0] BE_WORD = 4'b1111;
endpackage

// File: rtl/mips_sat_counter.sv
// mips_sat_counter: event counter that sticks at all-ones instead of wrapping
module mips_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);
    logic [W-1:0] count_q;
    // count up on each event until every bit is set
    always_ff @(posedge clk) begin
        if (rst) count_q <= '0;
        else if (inc_i && !(&count_q)) count_q <= count_q + W'(1);
    end
    assign count_o = count_q;
endmodule

// File: rtl/mips_cache_controller.sv
// mips_cache_controller: miss fill and write-through engine between a MIPS cache and an Avalon-MM memory
module mips_cache_controller
    import mips_cache_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             read_en,
    input  logic             write_en,
    input  logic [31:0]      writedata,
    input  logic [3:0]       byte_en,
    output logic             cpu_stall,
    input  logic             cache_stall,
    input  logic [31:0]      data_addr,
    output logic [31:0]      data_in,
    output logic             data_valid,
    output logic [31:0]      mem_address,
    output logic             mem_read,
    output logic             mem_write,
    output logic [31:0]      mem_writedata,
    output logic [3:0]       mem_byteenable,
    input  logic             mem_waitrequest,
    input  logic [31:0]      mem_readdata,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);
    state_e      state_q;
    logic [31:0] addr_q, wdata_q, data_in_q;
    logic [3:0]  be_q, mem_be_q;
    logic        is_wr_q, mem_read_q, mem_write_q;
    logic        req, hit_inc, miss_inc;
    // transaction sequencing; Avalon strobes are registered alongside the state they belong to
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            data_in_q   <= '0;
            is_wr_q     <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_be_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (read_en) begin
                        if (cache_stall) begin
                            addr_q     <= data_addr;
                            is_wr_q    <= 1'b0;
                            mem_read_q <= 1'b1;
                            mem_be_q   <= BE_WORD;
                            state_q    <= RD_WAIT;
                        end
                    end else if (write_en) begin
                        addr_q  <= data_addr;
                        wdata_q <= writedata;
                        be_q    <= byte_en;
                        is_wr_q <= 1'b1;
                        if (cache_stall && byte_en != BE_WORD) begin
                            mem_read_q <= 1'b1;
                            mem_be_q   <= BE_WORD;
                            state_q    <= RD_WAIT;
                        end else begin
                            mem_write_q <= 1'b1;
                            mem_be_q    <= byte_en;
                            state_q     <= WR_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    if (!mem_waitrequest) begin
                        data_in_q  <= mem_readdata;
                        mem_read_q <= 1'b0;
                        state_q    <= FILL;
                    end
                end
                FILL: begin
                    if (is_wr_q && data_addr == addr_q) begin
                        mem_write_q <= 1'b1;
                        mem_be_q    <= be_q;
                        state_q     <= WR_WAIT;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                WR_WAIT: begin
                    if (!mem_waitrequest) begin
                        mem_write_q <= 1'b0;
                        state_q     <= WR_DONE;
                    end
                end
                WR_DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
    // stall and fill strobe follow the current state; a fill whose address moved on is dropped
    always_comb begin
        cpu_stall  = (state_q == IDLE) ? (read_en ? cache_stall : write_en) : (state_q != WR_DONE);
        data_valid = (state_q == FILL) && (data_addr == addr_q);
        req        = (state_q == IDLE) && (read_en || write_en);
        hit_inc    = req && !cache_stall;
        miss_inc   = req && cache_stall;
    end
    assign data_in        = data_in_q;
    assign mem_address    = addr_q;
    assign mem_writedata  = wdata_q;
    assign mem_byteenable = mem_be_q;
    assign mem_read       = mem_read_q;
    assign mem_write      = mem_write_q;
    mips_sat_counter #(.W(CNT_W)) u_hit (
        .clk(clk), .rst(rst), .inc_i(hit_inc), .count_o(hit_count)
    );
    mips_sat_counter #(.W(CNT_W)) u_miss (
        .clk(clk), .rst(rst), .inc_i(miss_inc), .count_o(miss_count)
    );
endmodule
